hs_stream_source: RTL and testbench

Parametrised valid/ready stream source, the next generation of the team's handshake data generator. It emits framed bursts of programmable length from an internal RAM or a built-in ramp generator, with single-shot or continuous-loop modes, a `last` marker, and a graceful stop. Strict hold rules apply while a beat is stalled. It sits at the head of handshake test chains and drives a downstream sink through the `valid`/`ready` pair.

---
 rtl/hs_stream_source_if.sv | 12 +
 rtl/hs_stream_source.sv | 183 ++++++++++++++++++
 tb/tb_hs_stream_source.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_stream_source_if.sv
// Valid/ready stream bundle carrying the beats produced by hs_stream_source.
interface hs_stream_source_if #(
    parameter int WIDTH = 8
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data_out;
    logic             last;

    modport master (output valid, output data_out, output last, input ready);
    modport slave  (input valid, input data_out, input last, output ready);
endinterface

// File: rtl/hs_stream_source.sv
// Framed valid/ready burst generator fed from a local RAM or a ramp counter,
// with single-shot or looping runs and a frame-aligned graceful stop.
module hs_stream_source #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               s_rst_n,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_loop,
    input  logic               i_pat_sel,
    input  logic [AW:0]        i_len,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [WIDTH-1:0]   i_wr_data,
    output logic               o_busy,
    output logic               o_done,
    output logic [15:0]        o_frame_cnt,
    hs_stream_source_if.master o_stream
);

    typedef enum logic [1:0] {IDLE, PREFETCH, SEND} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_start_s1;
    logic             r_start_s2;
    logic             r_start_s3;
    logic             r_loop;
    logic             r_pat;
    logic             r_stop;
    logic [AW-1:0]    r_len_m1;
    logic [AW-1:0]    r_k;
    logic             r_valid;
    logic             r_last;
    logic             r_done;
    logic [WIDTH-1:0] r_data;
    logic [15:0]      r_frame_cnt;

    logic             w_start_rise;
    logic             w_xfer;
    logic             w_stop_seen;
    logic             w_capture;
    logic             w_load;
    logic             w_finish;
    logic             w_frame_done;
    logic [AW-1:0]    w_load_idx;
    logic [WIDTH-1:0] w_beat;
    logic [AW:0]      w_len_dec;
    logic [AW-1:0]    w_len_m1;

    assign w_start_rise = r_start_s2 & ~r_start_s3;
    assign w_xfer       = r_valid & o_stream.ready;
    assign w_stop_seen  = r_stop | i_stop;
    assign w_len_dec    = i_len - (AW+1)'(1);
    assign w_len_m1     = (i_len == '0 || i_len > (AW+1)'(DEPTH)) ? AW'(DEPTH - 1)
                                                                  : w_len_dec[AW-1:0];
    assign w_beat       = r_pat ? WIDTH'({1'b0, w_load_idx} + (AW+1)'(1))
                                : r_mem[w_load_idx];

    assign o_busy            = (r_state != IDLE);
    assign o_done            = r_done;
    assign o_frame_cnt       = r_frame_cnt;
    assign o_stream.valid    = r_valid;
    assign o_stream.data_out = r_data;
    assign o_stream.last     = r_last;

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_start_s1 <= 1'b0;
            r_start_s2 <= 1'b0;
            r_start_s3 <= 1'b0;
        end else begin
            r_start_s1 <= i_start;
            r_start_s2 <= r_start_s1;
            r_start_s3 <= r_start_s2;
        end
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A frame boundary in loop mode reloads beat 0 on the same edge, so no bubble appears.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_load       = 1'b0;
        w_finish     = 1'b0;
        w_frame_done = 1'b0;
        w_load_idx   = '0;
        unique case (r_state)
            IDLE: begin
                if (w_start_rise) begin
                    w_next_state = PREFETCH;
                    w_capture    = 1'b1;
                end
            end
            PREFETCH: begin
                w_next_state = SEND;
                w_load       = 1'b1;
            end
            SEND: begin
                if (w_xfer) begin
                    if (r_last) begin
                        w_frame_done = 1'b1;
                        if (r_loop && !w_stop_seen) begin
                            w_load = 1'b1;
                        end else begin
                            w_finish     = 1'b1;
                            w_next_state = IDLE;
                        end
                    end else begin
                        w_load     = 1'b1;
                        w_load_idx = r_k + AW'(1);
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_len_m1    <= '0;
            r_loop      <= 1'b0;
            r_pat       <= 1'b0;
            r_stop      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_capture) begin
                r_len_m1    <= w_len_m1;
                r_loop      <= i_loop;
                r_pat       <= i_pat_sel;
                r_stop      <= 1'b0;
                r_frame_cnt <= '0;
            end else begin
                if (o_busy && i_stop) begin
                    r_stop <= 1'b1;
                end
                if (w_frame_done) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
                end
            end
        end
    end

    // Output beat registers only change on a load or at run end, which keeps them stable while stalled.
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_k     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_valid <= 1'b1;
                r_k     <= w_load_idx;
                r_data  <= w_beat;
                r_last  <= (w_load_idx == r_len_m1);
            end else if (w_finish) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en && !o_busy) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

endmodule

// File: tb/tb_hs_stream_source.sv
// Directed self-checking bench for hs_stream_source: ramp/RAM frames, backpressure,
// full-depth wrap, loop with stop, reset mid-run and inputs ignored while busy.
module tb_hs_stream_source;

    localparam int WIDTH = 8;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic             clk = 1'b0;
    logic             s_rst_n;
    logic             i_start;
    logic             i_stop;
    logic             i_loop;
    logic             i_pat_sel;
    logic [AW:0]      i_len;
    logic             i_wr_en;
    logic [AW-1:0]    i_wr_addr;
    logic [WIDTH-1:0] i_wr_data;
    logic             o_busy;
    logic             o_done;
    logic [15:0]      o_frame_cnt;

    int               nAsserts = 0;
    int               nFails   = 0;
    int               doneCnt;
    logic [WIDTH-1:0] gotData [$];
    bit               gotLast [$];
    int               gotCyc  [$];
    logic [WIDTH-1:0] expData [$];
    bit               expLast [$];
    bit               rdyPat  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    hs_stream_source_if #(.WIDTH(WIDTH)) strm ();

    hs_stream_source #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .s_rst_n     (s_rst_n),
        .i_start     (i_start),
        .i_stop      (i_stop),
        .i_loop      (i_loop),
        .i_pat_sel   (i_pat_sel),
        .i_len       (i_len),
        .i_wr_en     (i_wr_en),
        .i_wr_addr   (i_wr_addr),
        .i_wr_data   (i_wr_data),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_frame_cnt (o_frame_cnt),
        .o_stream    (strm)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nAsserts++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raises start at a negedge (E0 is the next posedge) and checks the start latency.
    task automatic applyStimulus(input int len, input bit loopMode, input bit patSel);
        @(negedge clk);
        i_len     = (AW+1)'(len);
        i_loop    = loopMode;
        i_pat_sel = patSel;
        i_start   = 1'b1;
        @(negedge clk);
        checkOutput("lat_busy_E0", o_busy, 0);
        @(negedge clk);
        checkOutput("lat_busy_E1", o_busy, 0);
        @(negedge clk);
        checkOutput("lat_busy_E2", o_busy, 1);
        checkOutput("lat_valid_E2", strm.valid, 0);
        i_start = 1'b0;
    endtask

    // Drives ready, records transfers, checks stall stability, and runs until a couple of cycles past done.
    task automatic collectRun(input int budget, input bit useRdyPat, input int stopAfter, input bit meddle);
        bit               pv = 1'b0;
        bit               px = 1'b0;
        bit               pl = 1'b0;
        logic [WIDTH-1:0] pd = '0;
        bit               stopSent = 1'b0;
        int               tail = -1;
        gotData.delete();
        gotLast.delete();
        gotCyc.delete();
        doneCnt = 0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            strm.ready = useRdyPat ? rdyPat[cyc % 6] : 1'b1;
            i_stop = 1'b0;
            if (stopAfter >= 0 && !stopSent && gotData.size() == stopAfter) begin
                i_stop   = 1'b1;
                stopSent = 1'b1;
            end
            if (meddle && cyc == 0) begin
                i_wr_en   = 1'b1;
                i_wr_addr = 8'd3;
                i_wr_data = 8'hFF;
                i_start   = 1'b1;
            end else begin
                i_wr_en = 1'b0;
            end
            if (pv && !px) begin
                checkOutput("stall_valid", strm.valid, 1);
                checkOutput("stall_data", strm.data_out, pd);
                checkOutput("stall_last", strm.last, pl);
            end
            px = strm.valid && strm.ready;
            if (px) begin
                gotData.push_back(strm.data_out);
                gotLast.push_back(strm.last);
                gotCyc.push_back(cyc);
            end
            pv = strm.valid;
            pd = strm.data_out;
            pl = strm.last;
            if (o_done) begin
                doneCnt++;
                checkOutput("done_valid", strm.valid, 0);
                checkOutput("done_busy", o_busy, 0);
                if (tail < 0) tail = 3;
            end
            if (tail > 0) tail--;
            if (tail == 0) break;
        end
        i_stop  = 1'b0;
        i_start = 1'b0;
        checkOutput("run_ended", (tail == 0), 1);
        checkOutput("done_once", doneCnt, 1);
    endtask

    task automatic buildRamp(input int frameLen, input int frames);
        expData.delete();
        expLast.delete();
        for (int f = 0; f < frames; f++) begin
            for (int k = 0; k < frameLen; k++) begin
                expData.push_back(WIDTH'(k + 1));
                expLast.push_back(k == frameLen - 1);
            end
        end
    endtask

    task automatic checkBeats(input string tag, input bit contiguous);
        checkOutput({tag, "_count"}, gotData.size(), expData.size());
        for (int i = 0; i < expData.size() && i < gotData.size(); i++) begin
            checkOutput($sformatf("%s_data%0d", tag, i), gotData[i], expData[i]);
            checkOutput($sformatf("%s_last%0d", tag, i), gotLast[i], expLast[i]);
            if (contiguous && i > 0) begin
                checkOutput($sformatf("%s_gap%0d", tag, i), gotCyc[i] - gotCyc[i-1], 1);
            end
        end
    endtask

    task automatic writeRam(input int addr, input int value);
        @(negedge clk);
        i_wr_en   = 1'b1;
        i_wr_addr = AW'(addr);
        i_wr_data = WIDTH'(value);
        @(negedge clk);
        i_wr_en   = 1'b0;
    endtask

    initial begin
        int busyCnt;
        s_rst_n    = 1'b0;
        i_start    = 1'b0;
        i_stop     = 1'b0;
        i_loop     = 1'b0;
        i_pat_sel  = 1'b0;
        i_len      = '0;
        i_wr_en    = 1'b0;
        i_wr_addr  = '0;
        i_wr_data  = '0;
        strm.ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", strm.valid, 0);
        checkOutput("rst_last", strm.last, 0);
        checkOutput("rst_data", strm.data_out, 0);
        checkOutput("rst_busy", o_busy, 0);
        checkOutput("rst_done", o_done, 0);
        checkOutput("rst_frame_cnt", o_frame_cnt, 0);
        s_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(5, 1'b0, 1'b1);
        collectRun(50, 1'b0, -1, 1'b0);
        buildRamp(5, 1);
        checkBeats("ramp5", 1'b1);
        checkOutput("ramp5_first_cycle", gotCyc.size() > 0 ? gotCyc[0] : -1, 0);
        checkOutput("ramp5_frame_cnt", o_frame_cnt, 1);

        applyStimulus(1, 1'b0, 1'b1);
        collectRun(50, 1'b0, -1, 1'b0);
        buildRamp(1, 1);
        checkBeats("len1", 1'b1);

        for (int i = 0; i < 4; i++) writeRam(i, 8'hA0 + i);
        for (int i = 4; i < 8; i++) writeRam(i, 8'h55);
        applyStimulus(4, 1'b0, 1'b0);
        collectRun(80, 1'b1, -1, 1'b0);
        expData = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        expLast = '{1'b0, 1'b0, 1'b0, 1'b1};
        checkBeats("ram_bp", 1'b0);
        checkOutput("ram_bp_frame_cnt", o_frame_cnt, 1);

        applyStimulus(0, 1'b0, 1'b1);
        collectRun(400, 1'b0, -1, 1'b0);
        buildRamp(256, 1);
        checkBeats("full", 1'b1);

        applyStimulus(300, 1'b0, 1'b1);
        collectRun(400, 1'b0, -1, 1'b0);
        checkOutput("over_count", gotData.size(), 256);

        applyStimulus(3, 1'b1, 1'b1);
        collectRun(100, 1'b0, 4, 1'b0);
        buildRamp(3, 2);
        checkBeats("loop_stop", 1'b1);
        checkOutput("loop_stop_frame_cnt", o_frame_cnt, 2);

        applyStimulus(8, 1'b0, 1'b1);
        strm.ready = 1'b1;
        @(negedge clk);
        checkOutput("mid_beat0", strm.data_out, 1);
        @(negedge clk);
        checkOutput("mid_beat1", strm.data_out, 2);
        s_rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", strm.valid, 0);
        checkOutput("mid_rst_busy", o_busy, 0);
        checkOutput("mid_rst_last", strm.last, 0);
        checkOutput("mid_rst_frame_cnt", o_frame_cnt, 0);
        @(negedge clk);
        s_rst_n = 1'b1;
        busyCnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (o_busy || strm.valid) busyCnt++;
        end
        checkOutput("post_rst_idle", busyCnt, 0);
        applyStimulus(8, 1'b0, 1'b1);
        collectRun(60, 1'b0, -1, 1'b0);
        buildRamp(8, 1);
        checkBeats("replay", 1'b1);

        applyStimulus(4, 1'b0, 1'b0);
        collectRun(60, 1'b0, -1, 1'b1);
        expData = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        expLast = '{1'b0, 1'b0, 1'b0, 1'b1};
        checkBeats("busy_wr", 1'b1);
        busyCnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_busy) busyCnt++;
        end
        checkOutput("no_second_run", busyCnt, 0);
        applyStimulus(4, 1'b0, 1'b0);
        collectRun(60, 1'b0, -1, 1'b0);
        checkBeats("ram_kept", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule
